// File: rtl/sumador_pkg.sv
// Shared constants and state encoding for the bit-serial adder controller.
package sumador_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/sumador_completo_bit.sv
// Combinational 1-bit full adder built from two half adders and an OR.
module sumador_medio_bit (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    assign s  = a ^ b;
    assign co = a & b;

endmodule

module sumador_completo_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    sumador_medio_bit u_ha0 (
        .a  (a),
        .b  (b),
        .s  (s1),
        .co (c1)
    );

    sumador_medio_bit u_ha1 (
        .a  (s1),
        .b  (cin),
        .s  (s),
        .co (c2)
    );

    assign co = c1 | c2;

endmodule

// File: rtl/sumador_serial_ctrl.sv
// Bit-serial adder: LSB-first through one full adder, framed by start/busy/done.
module sumador_serial_ctrl
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_s;
    logic fa_co;

    sumador_completo_bit u_fa (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Next-state and datapath; busy/done are registered from the next state.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
